display_source_arbiter: RTL and testbench

- Selects which six-digit BCD source feeds the six-digit multiplexed 7-segment display controller.
- Sources: running time, alarm setting, world-clock time, and alarm-ringing indication.
- Arbitrates by fixed priority with a timed world-clock hold and per-digit blinking for edit and ring modes.
- Registered output; sits between the timekeeping/alarm/world-clock blocks and the display controller.

---
 rtl/display_pkg.sv | 61 ++++++
 rtl/blink_gen.sv | 50 +++++
 rtl/display_source_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_display_source_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display source arbiter.
// Contents: state codes, blank code, digit index constants,
// the six-digit bundle struct and slice helpers.
package display_pkg;

  localparam int unsigned BUNDLE_W = 24;

  // State codes double as the src output value
  localparam logic [1:0] S_TIME  = 2'd0;
  localparam logic [1:0] S_WORLD = 2'd1;
  localparam logic [1:0] S_EDIT  = 2'd2;
  localparam logic [1:0] S_RING  = 2'd3;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Digit indices, most significant digit first (matches edit_pos)
  localparam logic [2:0] DIG_H_TEN = 3'd0;
  localparam logic [2:0] DIG_H_ONE = 3'd1;
  localparam logic [2:0] DIG_M_TEN = 3'd2;
  localparam logic [2:0] DIG_M_ONE = 3'd3;
  localparam logic [2:0] DIG_S_TEN = 3'd4;
  localparam logic [2:0] DIG_S_ONE = 3'd5;

  typedef struct packed {
    logic [3:0] h_ten;
    logic [3:0] h_one;
    logic [3:0] m_ten;
    logic [3:0] m_one;
    logic [3:0] s_ten;
    logic [3:0] s_one;
  } digits_t;

  // Read one digit of a bundle by index; out-of-range returns blank
  function automatic logic [3:0] dig_get(input digits_t b, input logic [2:0] idx);
    logic [3:0] d;
    case (idx)
      DIG_H_TEN: d = b.h_ten;
      DIG_H_ONE: d = b.h_one;
      DIG_M_TEN: d = b.m_ten;
      DIG_M_ONE: d = b.m_one;
      DIG_S_TEN: d = b.s_ten;
      DIG_S_ONE: d = b.s_one;
      default:   d = BLANK_CODE;
    endcase
    return d;
  endfunction

  // Force every digit whose mask bit is set to the blank code
  function automatic digits_t dig_blank(input digits_t b, input logic [5:0] mask);
    digits_t r;
    r = b;
    if (mask[DIG_H_TEN]) r.h_ten = BLANK_CODE;
    if (mask[DIG_H_ONE]) r.h_one = BLANK_CODE;
    if (mask[DIG_M_TEN]) r.m_ten = BLANK_CODE;
    if (mask[DIG_M_ONE]) r.m_one = BLANK_CODE;
    if (mask[DIG_S_TEN]) r.s_ten = BLANK_CODE;
    if (mask[DIG_S_ONE]) r.s_one = BLANK_CODE;
    return r;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: blink_on toggles every BLINK_HALF clk cycles.
// Ports: clk, rst (async, active-high), restart (clear count, force visible),
//        blink_on (registered phase), blink_nxt_c (phase after this edge).
module blink_gen #(
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic blink_on,
  output logic blink_nxt_c
);

  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_on;
  logic             w_on_nxt;

  // Next count/phase; restart wins so a new view starts visible
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_on_nxt  = r_on;
    if (restart) begin
      w_cnt_nxt = '0;
      w_on_nxt  = 1'b1;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_nxt = '0;
      w_on_nxt  = ~r_on;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_on  <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_on  <= w_on_nxt;
    end
  end

  assign blink_on    = r_on;
  assign blink_nxt_c = w_on_nxt;

endmodule

// File: rtl/display_source_arbiter.sv
// Selects which six-digit source drives the 7-segment display controller.
// Priority RING > EDIT > WORLD > TIME, timed world-clock hold, per-digit blink
// in edit mode and whole-display blink while ringing. Outputs are registered.
// Optional macro ARB_SNOOZE_EN adds a snooze input that defers ring re-entry.
// Ports: clk, rst (async, active-high), tick_1hz, time/alarm/world_digits,
//        world_req, alarm_edit, edit_pos, alarm_ring, ring_ack, snooze,
//        h_ten..s_one (digit outputs), src (active state code).
module display_source_arbiter
  import display_pkg::*;
#(
  parameter int unsigned HOLD_SEC   = 5,
  parameter int unsigned BLINK_HALF = 12_500_000,
  parameter int unsigned SNOOZE_SEC = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_1hz,
  input  logic [BUNDLE_W-1:0] time_digits,
  input  logic [BUNDLE_W-1:0] alarm_digits,
  input  logic [BUNDLE_W-1:0] world_digits,
  input  logic                world_req,
  input  logic                alarm_edit,
  input  logic [2:0]          edit_pos,
  input  logic                alarm_ring,
  input  logic                ring_ack,
  input  logic                snooze,
  output logic [3:0]          h_ten,
  output logic [3:0]          h_one,
  output logic [3:0]          m_ten,
  output logic [3:0]          m_one,
  output logic [3:0]          s_ten,
  output logic [3:0]          s_one,
  output logic [1:0]          src
);

  localparam int unsigned HOLD_W = ($clog2(HOLD_SEC + 1) > 0) ? $clog2(HOLD_SEC + 1) : 1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_ack_hold;
  logic              w_ack_hold_nxt;
  digits_t           r_digits;
  digits_t           w_digits_nxt;
  logic [5:0]        w_mask;
  logic              w_restart;
  logic              w_blink_on;
  logic              w_blink_nxt;
  logic              w_snooze_exit;
  logic              w_ring_inhibit;
  logic              w_ring_ok;
  logic              w_unused;

`ifdef ARB_SNOOZE_EN
  localparam int unsigned SNZ_W = ($clog2(SNOOZE_SEC + 1) > 0) ? $clog2(SNOOZE_SEC + 1) : 1;

  logic [SNZ_W-1:0] r_snooze_cnt;
  logic [SNZ_W-1:0] w_snooze_nxt;

  assign w_snooze_exit  = snooze;
  assign w_ring_inhibit = (r_snooze_cnt != '0);

  // Snooze countdown; ack or alarm release cancels any pending snooze
  always_comb begin
    w_snooze_nxt = r_snooze_cnt;
    if (tick_1hz && (r_snooze_cnt != '0))
      w_snooze_nxt = r_snooze_cnt - SNZ_W'(1);
    if ((r_state == S_RING) && snooze && alarm_ring && !ring_ack)
      w_snooze_nxt = SNZ_W'(SNOOZE_SEC);
    if (ring_ack || !alarm_ring)
      w_snooze_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_snooze_cnt <= '0;
    else     r_snooze_cnt <= w_snooze_nxt;
  end

  assign w_unused = w_blink_on;
`else
  assign w_snooze_exit  = 1'b0;
  assign w_ring_inhibit = 1'b0;
  assign w_unused       = &{1'b0, w_blink_on, snooze, (SNOOZE_SEC != 0)};
`endif

  assign w_ring_ok = alarm_ring && !r_ack_hold && !w_ring_inhibit;

  // Next-state, hold counter and acknowledge latch
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold_cnt;
    w_ack_hold_nxt = r_ack_hold;

    case (r_state)
      S_RING: begin
        if (!alarm_ring || ring_ack || w_snooze_exit)
          w_state_nxt = alarm_edit ? S_EDIT : S_TIME;
      end
      default: begin
        if (w_ring_ok) begin
          w_state_nxt = S_RING;
        end else if (alarm_edit) begin
          w_state_nxt = S_EDIT;
        end else if (r_state == S_EDIT) begin
          w_state_nxt = S_TIME;
        end else if (r_state == S_WORLD) begin
          // A fresh request reloads even if a tick lands in the same cycle
          if (world_req) begin
            w_hold_nxt = HOLD_W'(HOLD_SEC);
          end else if (tick_1hz) begin
            if (r_hold_cnt == HOLD_W'(1)) w_state_nxt = S_TIME;
            else                          w_hold_nxt  = r_hold_cnt - HOLD_W'(1);
          end
        end else if (world_req) begin
          w_state_nxt = S_WORLD;
          w_hold_nxt  = HOLD_W'(HOLD_SEC);
        end
      end
    endcase

    // Leaving the world view in any way discards the remaining hold
    if (w_state_nxt != S_WORLD) w_hold_nxt = '0;

    // Ack only suppresses re-entry while the same alarm condition persists
    if (!alarm_ring)
      w_ack_hold_nxt = 1'b0;
    else if ((r_state == S_RING) && ring_ack)
      w_ack_hold_nxt = 1'b1;
  end

  assign w_restart = (w_state_nxt != r_state) &&
                     ((w_state_nxt == S_EDIT) || (w_state_nxt == S_RING));

  blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink_gen (
    .clk         (clk),
    .rst         (rst),
    .restart     (w_restart),
    .blink_on    (w_blink_on),
    .blink_nxt_c (w_blink_nxt)
  );

  // Output mux uses the blink phase that is current once this edge lands,
  // so displayed digits and blink_on stay in step
  always_comb begin
    w_mask       = 6'b0;
    w_digits_nxt = digits_t'(time_digits);
    case (w_state_nxt)
      S_WORLD: w_digits_nxt = digits_t'(world_digits);
      S_EDIT: begin
        w_digits_nxt = digits_t'(alarm_digits);
        if (!w_blink_nxt && (edit_pos < 3'd6))
          w_mask = 6'b000001 << edit_pos;
      end
      S_RING: begin
        if (!w_blink_nxt) w_mask = 6'b111111;
      end
      default: w_digits_nxt = digits_t'(time_digits);
    endcase
    w_digits_nxt = dig_blank(w_digits_nxt, w_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_TIME;
      r_hold_cnt <= '0;
      r_ack_hold <= 1'b0;
      r_digits   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_ack_hold <= w_ack_hold_nxt;
      r_digits   <= w_digits_nxt;
    end
  end

  assign src   = r_state;
  assign h_ten = r_digits.h_ten;
  assign h_one = r_digits.h_one;
  assign m_ten = r_digits.m_ten;
  assign m_one = r_digits.m_one;
  assign s_ten = r_digits.s_ten;
  assign s_one = r_digits.s_one;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed testbench for display_source_arbiter (HOLD_SEC=3, BLINK_HALF=4,
// SNOOZE_SEC=2). Table of single-cycle vectors plus hand-written sequences.
module tb_display_source_arbiter;

  localparam int unsigned HOLD  = 3;
  localparam int unsigned BLINK = 4;
  localparam int unsigned SNZ   = 2;

  localparam logic [23:0] T0 = 24'h123456;
  localparam logic [23:0] T1 = 24'h235959;
  localparam logic [23:0] A  = 24'h071500;
  localparam logic [23:0] AB = 24'h07F500;
  localparam logic [23:0] W  = 24'h987654;
  localparam logic [23:0] X  = 24'hABCDEF;
  localparam logic [23:0] BL = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic [23:0] time_digits, alarm_digits, world_digits;
  logic        world_req, alarm_edit, alarm_ring, ring_ack, snooze;
  logic [2:0]  edit_pos;
  logic [3:0]  h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic [1:0]  src;
  logic [23:0] out_dig;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [23:0] t, a, w;
    logic        wreq, edit;
    logic [2:0]  pos;
    logic        ring, ack;
    logic [1:0]  e_src;
    logic [23:0] e_dig;
  } vec_t;

  vec_t vecs [16];

  display_source_arbiter #(
    .HOLD_SEC   (HOLD),
    .BLINK_HALF (BLINK),
    .SNOOZE_SEC (SNZ)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .time_digits  (time_digits),
    .alarm_digits (alarm_digits),
    .world_digits (world_digits),
    .world_req    (world_req),
    .alarm_edit   (alarm_edit),
    .edit_pos     (edit_pos),
    .alarm_ring   (alarm_ring),
    .ring_ack     (ring_ack),
    .snooze       (snooze),
    .h_ten        (h_ten),
    .h_one        (h_one),
    .m_ten        (m_ten),
    .m_one        (m_one),
    .s_ten        (s_ten),
    .s_one        (s_one),
    .src          (src)
  );

  always #5 clk = ~clk;

  assign out_dig = {h_ten, h_one, m_ten, m_one, s_ten, s_one};

  function automatic vec_t mk(input logic [23:0] t, input logic [23:0] a,
                              input logic [23:0] w, input logic wreq,
                              input logic edit, input logic [2:0] pos,
                              input logic ring, input logic ack,
                              input logic [1:0] e_src, input logic [23:0] e_dig);
    vec_t v;
    v.t = t; v.a = a; v.w = w; v.wreq = wreq; v.edit = edit; v.pos = pos;
    v.ring = ring; v.ack = ack; v.e_src = e_src; v.e_dig = e_dig;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] e_src, input logic [23:0] e_dig);
    n_checks++;
    if (src !== e_src || out_dig !== e_dig) begin
      n_errors++;
      $display("FAIL %s: got src=%0d digits=%06h, expected src=%0d digits=%06h",
               name, src, out_dig, e_src, e_dig);
    end
  endtask

  task automatic check_src(input string name, input logic [1:0] e_src);
    n_checks++;
    if (src !== e_src) begin
      n_errors++;
      $display("FAIL %s: got src=%0d, expected src=%0d", name, src, e_src);
    end
  endtask

  // One cycle with optional tick / world_req pulses
  task automatic step_in(input logic t, input logic w);
    tick_1hz  = t;
    world_req = w;
    step();
    tick_1hz  = 1'b0;
    world_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick_1hz = 1'b0; world_req = 1'b0; alarm_edit = 1'b0; alarm_ring = 1'b0;
    ring_ack = 1'b0; snooze = 1'b0; edit_pos = 3'd2;
    time_digits = T0; alarm_digits = A; world_digits = W;

    vecs[0]  = mk(T0, A, W, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, T0);
    vecs[1]  = mk(T1, A, W, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, T1);
    vecs[2]  = mk(T1, A, W, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 2'd1, W);
    vecs[3]  = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd1, X);
    vecs[4]  = mk(T1, A, X, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 2'd2, A);
    vecs[5]  = mk(T1, A, X, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 2'd2, A);
    vecs[6]  = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, T1);
    vecs[7]  = mk(T1, A, X, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 2'd3, T1);
    vecs[8]  = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 2'd3, T1);
    vecs[9]  = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd0, T1);
    vecs[10] = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 2'd0, T1);
    vecs[11] = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, T1);
    vecs[12] = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 2'd3, T1);
    vecs[13] = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 2'd0, T1);
    vecs[14] = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 2'd3, T1);
    vecs[15] = mk(T1, A, X, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, T1);

    // Reset values, then pass-through of time digits
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 2'd0, 24'h000000);
    rst = 1'b0;
    step();
    check("reset_release_time", 2'd0, T0);

    // Single-cycle vector table
    for (int i = 0; i < 16; i++) begin
      time_digits  = vecs[i].t;
      alarm_digits = vecs[i].a;
      world_digits = vecs[i].w;
      world_req    = vecs[i].wreq;
      alarm_edit   = vecs[i].edit;
      edit_pos     = vecs[i].pos;
      alarm_ring   = vecs[i].ring;
      ring_ack     = vecs[i].ack;
      step();
      check($sformatf("vec%0d", i), vecs[i].e_src, vecs[i].e_dig);
    end
    world_req = 1'b0; ring_ack = 1'b0; alarm_ring = 1'b0; alarm_edit = 1'b0;
    time_digits = T0; alarm_digits = A; world_digits = W; edit_pos = 3'd2;
    step();

    // World hold: returns on the cycle after the third tick
    step_in(1'b0, 1'b1); check("hold_enter", 2'd1, W);
    step_in(1'b1, 1'b0); check("hold_tick1", 2'd1, W);
    step_in(1'b0, 1'b0); check("hold_idle", 2'd1, W);
    step_in(1'b1, 1'b0); check("hold_tick2", 2'd1, W);
    step_in(1'b1, 1'b0); check("hold_tick3_exit", 2'd0, T0);

    // Request after the second tick extends by a full hold
    step_in(1'b0, 1'b1); check("ext_enter", 2'd1, W);
    step_in(1'b1, 1'b0); check("ext_tick1", 2'd1, W);
    step_in(1'b1, 1'b0); check("ext_tick2", 2'd1, W);
    step_in(1'b0, 1'b1); check("ext_reload", 2'd1, W);
    step_in(1'b1, 1'b0); check("ext_tick_a", 2'd1, W);
    step_in(1'b1, 1'b0); check("ext_tick_b", 2'd1, W);
    step_in(1'b1, 1'b0); check("ext_tick_c_exit", 2'd0, T0);

    // Reload beats a tick arriving in the same cycle
    step_in(1'b0, 1'b1); check("race_enter", 2'd1, W);
    step_in(1'b1, 1'b0); check("race_tick1", 2'd1, W);
    step_in(1'b1, 1'b0); check("race_tick2", 2'd1, W);
    step_in(1'b1, 1'b1); check("race_reload_wins", 2'd1, W);
    step_in(1'b1, 1'b0); check("race_tick_a", 2'd1, W);
    step_in(1'b1, 1'b0); check("race_tick_b", 2'd1, W);
    step_in(1'b1, 1'b0); check("race_tick_c_exit", 2'd0, T0);

    // Edit blink on m_ten, 4 cycles visible then 4 blanked
    alarm_edit = 1'b1; edit_pos = 3'd2;
    for (int j = 0; j < 16; j++) begin
      step();
      check($sformatf("edit_blink%0d", j), 2'd2, (((j / 4) % 2) == 0) ? A : AB);
    end
    edit_pos = 3'd6;
    for (int j = 0; j < 8; j++) begin
      step();
      check($sformatf("edit_pos6_%0d", j), 2'd2, A);
    end
    alarm_edit = 1'b0; edit_pos = 3'd2;
    step(); check("edit_exit", 2'd0, T0);

    // Ring preempts world, whole display blinks
    step_in(1'b0, 1'b1); check("ring_world_enter", 2'd1, W);
    alarm_ring = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      check($sformatf("ring_blink%0d", j), 2'd3, (((j / 4) % 2) == 0) ? T0 : BL);
    end
    ring_ack = 1'b1; step(); ring_ack = 1'b0;
    check("ring_ack_exit", 2'd0, T0);
    for (int j = 0; j < 3; j++) begin
      step(); check($sformatf("ring_ack_held%0d", j), 2'd0, T0);
    end
    alarm_ring = 1'b0; step(); check("ring_released", 2'd0, T0);
    alarm_ring = 1'b1; step(); check("ring_reenter", 2'd3, T0);
    alarm_ring = 1'b0; step(); check("ring_fall_exit", 2'd0, T0);

    // Ring over edit, falling alarm returns to edit with blink restarted
    alarm_edit = 1'b1; step(); check("edit_before_ring", 2'd2, A);
    alarm_ring = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(); check($sformatf("ring_over_edit%0d", j), 2'd3, (j < 4) ? T0 : BL);
    end
    alarm_ring = 1'b0; step(); check("edit_after_ring", 2'd2, A);
    for (int j = 1; j < 5; j++) begin
      step(); check($sformatf("edit_after_ring%0d", j), 2'd2, (j < 4) ? A : AB);
    end
    alarm_edit = 1'b0; step(); check("edit_after_ring_exit", 2'd0, T0);

`ifdef ARB_SNOOZE_EN
    // Snooze defers re-entry by SNOOZE_SEC ticks
    alarm_ring = 1'b1; step(); check_src("snz_ring", 2'd3);
    snooze = 1'b1; step(); snooze = 1'b0;
    check_src("snz_exit", 2'd0);
    step(); check_src("snz_wait", 2'd0);
    step_in(1'b1, 1'b0); check_src("snz_tick1", 2'd0);
    step_in(1'b1, 1'b0); check_src("snz_tick2", 2'd0);
    step(); check_src("snz_reenter", 2'd3);
    ring_ack = 1'b1; step(); ring_ack = 1'b0;
    check_src("snz_ack", 2'd0);
    alarm_ring = 1'b0; step(); check_src("snz_clear", 2'd0);
`else
    // Snooze has no effect in the default build
    alarm_ring = 1'b1; step(); check_src("snz_ring", 2'd3);
    snooze = 1'b1; step(); snooze = 1'b0;
    check_src("snz_ignored", 2'd3);
    step(); check_src("snz_ignored_hold", 2'd3);
    ring_ack = 1'b1; step(); ring_ack = 1'b0;
    check_src("snz_ack", 2'd0);
    alarm_ring = 1'b0; step(); check_src("snz_clear", 2'd0);
`endif

    // Asynchronous reset mid-operation drops the world view
    step_in(1'b0, 1'b1); check("pre_reset_world", 2'd1, W);
    rst = 1'b1;
    #1;
    check("async_reset", 2'd0, 24'h000000);
    step();
    rst = 1'b0;
    step(); check("post_reset_time", 2'd0, T0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
